// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag controller: FSM encoding, default
// geometry and associativity.
package cache_pkg;

    localparam int DEF_TAG_WIDTH  = 13;
    localparam int DEF_SET_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int NUM_WAYS       = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/address_decoder.sv
// Splits a line address into its tag (upper bits) and set index (lower bits).
module address_decoder
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int SET_WIDTH = DEF_SET_WIDTH
) (
    input  logic [TAG_WIDTH+SET_WIDTH-1:0] addr,
    output logic [TAG_WIDTH-1:0]           tag,
    output logic [SET_WIDTH-1:0]           set_index
);

    assign tag       = addr[TAG_WIDTH+SET_WIDTH-1:SET_WIDTH];
    assign set_index = addr[SET_WIDTH-1:0];

endmodule

// File: rtl/cache_tag_ctrl.sv
// Read-only 2-way set-associative cache controller, one data word per line,
// with per-set LRU and a single outstanding line-fill request.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int SET_WIDTH  = DEF_SET_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_WIDTH+SET_WIDTH-1:0] req_addr,
    output logic                           resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_hit,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [TAG_WIDTH+SET_WIDTH-1:0] mem_req_addr,
    input  logic                           mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_resp_data
);

    localparam int ADDR_WIDTH = TAG_WIDTH + SET_WIDTH;
    localparam int NUM_SETS   = 1 << SET_WIDTH;

    logic [TAG_WIDTH-1:0]  req_tag;
    logic [SET_WIDTH-1:0]  req_set;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [TAG_WIDTH-1:0]  tag_reg;
    logic [SET_WIDTH-1:0]  set_reg;

    logic [NUM_SETS-1:0]   valid_reg [NUM_WAYS];
    logic [NUM_SETS-1:0]   lru_reg;

    logic [NUM_WAYS-1:0]                 way_match;
    logic [NUM_WAYS-1:0][DATA_WIDTH-1:0] way_data;
    logic [NUM_WAYS-1:0]                 fill_we;

    logic                  accept;
    logic                  fill;
    logic                  hit;
    logic                  hit_way;
    logic                  victim;

    address_decoder #(
        .TAG_WIDTH (TAG_WIDTH),
        .SET_WIDTH (SET_WIDTH)
    ) u_address_decoder (
        .addr      (req_addr),
        .tag       (req_tag),
        .set_index (req_set)
    );

    assign accept = (state_reg == IDLE) && req_valid && req_ready;
    // Gating with rst keeps an aborted fill from touching the arrays.
    assign fill   = (state_reg == MEM_WAIT) && mem_resp_valid && !rst;

    // Tag/data arrays are plain block RAMs with a registered read port. The
    // read is issued every IDLE cycle with the incoming set index so the
    // accepted request's line is sitting in the read registers during LOOKUP.
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SETS];
        logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];
        logic [TAG_WIDTH-1:0]  tag_rd;
        logic [DATA_WIDTH-1:0] data_rd;

        assign fill_we[gi] = fill && (victim == 1'(gi));

        always_ff @(posedge clk) begin
            if (fill_we[gi]) begin
                tag_mem[set_reg]  <= tag_reg;
                data_mem[set_reg] <= mem_resp_data;
            end
            if (state_reg == IDLE) begin
                tag_rd  <= tag_mem[req_set];
                data_rd <= data_mem[req_set];
            end
        end

        assign way_match[gi] = valid_reg[gi][set_reg] && (tag_rd == tag_reg);
        assign way_data[gi]  = data_rd;
    end

    // A double match can only come from corruption; way0 wins.
    assign hit     = |way_match;
    assign hit_way = way_match[0] ? 1'b0 : 1'b1;

    always_comb begin
        victim = lru_reg[set_reg];
        if (!valid_reg[0][set_reg]) begin
            victim = 1'b0;
        end else if (!valid_reg[1][set_reg]) begin
            victim = 1'b1;
        end
    end

    // LRU bit names the way to evict next, i.e. the one not just used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            addr_reg      <= '0;
            tag_reg       <= '0;
            set_reg       <= '0;
            lru_reg       <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_reg[w] <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= req_addr;
                        tag_reg   <= req_tag;
                        set_reg   <= req_set;
                        req_ready <= 1'b0;
                        state_reg <= LOOKUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b1;
                        resp_data        <= way_data[hit_way];
                        lru_reg[set_reg] <= ~hit_way;
                        state_reg        <= RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= addr_reg;
                        state_reg     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_reg     <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_reg[victim][set_reg] <= 1'b1;
                        lru_reg[set_reg]           <= ~victim;
                        resp_valid                 <= 1'b1;
                        resp_hit                   <= 1'b0;
                        resp_data                  <= mem_resp_data;
                        state_reg                  <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: expected responses are queued at
// request time and compared when resp_valid pulses.
module tb_cache_tag_ctrl;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_hit;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    typedef struct {
        logic          hit;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   resp_cnt = 0;
    logic prev_rv  = 1'b0;

    cache_tag_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        if (resp_valid) begin
            chk("resp_pulse_width", prev_rv, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_hit", resp_hit, e.hit);
                chk("resp_data", resp_data, e.data);
                if (e.hit) chk("hit_latency", cyc - e.acc, 2);
                $display("resp: hit=%0b data=%08h latency=%0d", resp_hit, resp_data, cyc - e.acc);
            end
            resp_cnt++;
        end
        prev_rv <= resp_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", 1'b0, 1'b1);
    endtask

    // One read transaction; a miss is served by the bench memory after bp
    // cycles of mem_req_ready backpressure.
    task automatic do_read(input logic [AW-1:0] addr, input logic exp_hit,
                           input logic [DW-1:0] data, input int bp);
        bit ok;
        bit mem_seen = 0;
        int start;
        int n = 0;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_addr  = addr;
        exp_q.push_back('{exp_hit, data, cyc});
        start = resp_cnt;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom_range(0, (1 << AW) - 1);
        while (resp_cnt == start && n < 60) begin
            if (mem_req_valid) begin
                mem_seen = 1;
                chk("mem_req_addr", mem_req_addr, addr);
                for (int k = 0; k < bp; k++) begin
                    tick();
                    chk("bp_mem_req_valid", mem_req_valid, 1'b1);
                    chk("bp_mem_req_addr", mem_req_addr, addr);
                    chk("bp_req_ready", req_ready, 1'b0);
                end
                mem_req_ready = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                repeat (2) tick();
                chk("mem_req_dropped", mem_req_valid, 1'b0);
                mem_resp_valid = 1'b1;
                mem_resp_data  = data;
                tick();
                mem_resp_valid = 1'b0;
                mem_resp_data  = $urandom;
            end else begin
                tick();
            end
            n++;
        end
        if (resp_cnt == start) chk("resp_timeout", 1'b0, 1'b1);
        chk("mem_req_issued", mem_seen, !exp_hit);
        tick();
        chk("req_ready_after_resp", req_ready, 1'b1);
        $display("read %06h: expect_hit=%0b mem_req=%0b", addr, exp_hit, mem_seen);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_hit"}, resp_hit, 1'b0);
        chk({tag, "_resp_data"}, resp_data, 32'h0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 21'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int snap;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Cold miss, then hit on the same line.
        do_read(21'h000105, 1'b0, 32'hDEADBEEF, 0);
        do_read(21'h000105, 1'b1, 32'hDEADBEEF, 0);

        // Replacement in set 0x05: tag1 touched between fills, tag2 evicted.
        do_read(21'h000205, 1'b0, 32'h22222222, 0);
        do_read(21'h000105, 1'b1, 32'hDEADBEEF, 0);
        do_read(21'h000305, 1'b0, 32'h33333333, 0);
        do_read(21'h000105, 1'b1, 32'hDEADBEEF, 0);
        do_read(21'h000305, 1'b1, 32'h33333333, 0);
        // tag2 must miss again; serve it under 5 cycles of backpressure.
        do_read(21'h000205, 1'b0, 32'h22220002, 5);
        do_read(21'h000205, 1'b1, 32'h22220002, 0);

        // Extreme address: top tag, last set.
        do_read(21'h1FFFFF, 1'b0, 32'hA5A5A5A5, 0);
        do_read(21'h1FFFFF, 1'b1, 32'hA5A5A5A5, 0);

        // Spurious fill data while idle must not populate anything.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h44444444;
        repeat (3) tick();
        mem_resp_valid = 1'b0;
        chk("spurious_no_resp", resp_valid, 1'b0);
        do_read(21'h000405, 1'b0, 32'h40404040, 0);

        // Reset while waiting for fill data.
        wait_ready(ok);
        req_valid = 1'b1;
        req_addr  = 21'h000505;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rst_case_mem_req", mem_req_valid, 1'b1);
        chk("rst_case_mem_addr", mem_req_addr, 21'h000505);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        snap = resp_cnt;
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55555555;
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b0;
        check_reset_outputs("midrst");
        repeat (3) tick();
        chk("midrst_no_resp", resp_cnt - snap, 0);
        $display("reset during MEM_WAIT applied");

        // Everything must miss after the abort.
        do_read(21'h000505, 1'b0, 32'h50505050, 0);
        do_read(21'h000105, 1'b0, 32'h10101010, 0);
        do_read(21'h000105, 1'b1, 32'h10101010, 0);

        repeat (2) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 13, tag bits per address.
REQ-002 SHALL have parameter SET_WIDTH, default 8, set-index bits (2**SET_WIDTH sets).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, one data word per line.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have ports: req_valid in 1 request; req_ready out 1 accept; req_addr in TAG_WIDTH+SET_WIDTH read address.
REQ-006 SHALL have ports: resp_valid out 1 one-cycle response pulse; resp_data out DATA_WIDTH read data; resp_hit out 1 response was a hit.
REQ-007 SHALL have ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out TAG_WIDTH+SET_WIDTH line-fill request.
REQ-008 SHALL have ports: mem_resp_valid in 1; mem_resp_data in DATA_WIDTH fill data.

Function
REQ-009 SHALL implement a read-only, 2-way set-associative cache with per-way valid bit, tag and data word per set, plus one LRU bit per set.
REQ-010 SHALL split req_addr into tag (upper TAG_WIDTH bits) and set_index (lower SET_WIDTH bits).
REQ-011 SHALL run FSM states IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
REQ-012 SHALL assert req_ready only in IDLE; handshake when req_valid&&req_ready registers req_addr and moves IDLE->LOOKUP.
REQ-013 SHALL in LOOKUP compare registered tag against both ways of the set; hit = valid&&tag match; hit -> RESP, miss -> MEM_REQ.
REQ-014 SHALL on hit return the hitting way's data with resp_hit=1; hit latency = resp_valid 2 cycles after the accept cycle.
REQ-015 SHALL in MEM_REQ drive mem_req_valid=1 and mem_req_addr=registered address, held stable until mem_req_ready; transfer cycle moves MEM_REQ->MEM_WAIT.
REQ-016 SHALL in MEM_WAIT ignore nothing but mem_resp_valid; on mem_resp_valid write tag/data/valid into the victim way and move to RESP with resp_data=mem_resp_data, resp_hit=0.
REQ-017 SHALL select victim: way0 if invalid, else way1 if invalid, else the way indicated by LRU bit.
REQ-018 SHALL on hit or fill set the set's LRU bit to point at the way not just used.
REQ-019 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE (req_ready high the next cycle).
REQ-020 SHALL ignore mem_resp_valid outside MEM_WAIT and req_valid outside IDLE.
REQ-021 SHALL treat both ways matching (illegal) as a hit on way0.
REQ-022 SHALL hold resp_data/resp_hit stable except in the RESP cycle value update; outputs other than resp_valid are don't-care when resp_valid=0 but SHALL not be X.

Reset
REQ-023 SHALL on rst: FSM=IDLE, all valid bits=0, all LRU bits=0, req_ready=0 during reset, resp_valid=0, resp_hit=0, resp_data=0, mem_req_valid=0, mem_req_addr=0.
REQ-024 SHALL abort any in-flight request on rst mid-operation without producing resp_valid or writing the arrays; tag/data arrays need no reset.

Structure
REQ-025 SHALL place in shared package cache_pkg: FSM state enum, default TAG_WIDTH/SET_WIDTH/DATA_WIDTH constants, way count (2).
REQ-026 SHALL instantiate the existing address_decoder sub-module for the tag/set split; no other sub-modules.

Verification
REQ-027 SHALL cover cold miss: after reset, read 0x000105 -> mem_req_addr=0x000105, fill 0xDEADBEEF -> resp_hit=0, resp_data=0xDEADBEEF.
REQ-028 SHALL cover hit: repeat read 0x000105 -> no mem_req_valid, resp_valid exactly 2 cycles after accept, resp_hit=1, data 0xDEADBEEF.
REQ-029 SHALL cover replacement: fill tags 1,2,3 in set 0x05, access tag1 between -> tag2 evicted; re-read tag1 hits, tag2 misses.
REQ-030 SHALL cover backpressure: mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr stable throughout, req_ready=0.
REQ-031 SHALL cover spurious mem_resp_valid in IDLE -> no array write, subsequent read of that address misses.
REQ-032 SHALL cover rst asserted in MEM_WAIT -> no resp_valid, all outputs at reset values next cycle, later read misses.
